pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives the hold/clear inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold.
- Handles four cases: data-memory wait, branch flush, load-use stall, and multi-cycle mult/div occupancy.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LAT, 4, mult/div latency in cycles; must be >= 1.
- CNT_W, 32, width of the stall_cycles counter.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  RA_W each  source register addresses of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_md_use  in  1  ID instruction is mfhi/mflo/mult/div (needs HI/LO or the unit)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  RA_W  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- ex_md_start  in  1  EX instruction issues mult/div
- mem_stall  in  1  data memory not ready in MEM
- pc_hold  out  1  PC hold
- ifid_hold, ifid_clear  out  1 each  IF/ID register controls
- idex_hold, idex_clear  out  1 each  ID/EX register controls
- exmem_hold, exmem_clear  out  1 each  EX/MEM register controls
- memwb_hold, memwb_clear  out  1 each  MEM/WB register controls
- md_busy  out  1  mult/div unit occupied
- hazard_cause  out  3  encoded cause of this cycle's action (see package)
- stall_cycles  out  CNT_W  count of cycles with pc_hold=1

Behaviour:
- Hold/clear outputs are combinational from the inputs and registered state. A clear always overrides a hold in the registers.
- Never assert hold and clear on the same register in the same cycle.

Reset:
- While reset=1: all *_clear=1, all *_hold=0, pc_hold=0, md_busy=0, stall_cycles=0, FSM in IDLE.
- Reset mid-operation abandons a busy mult/div count.

Priority, highest first; exactly one case applies per cycle:
1. MEM_STALL (mem_stall=1): pc_hold, ifid_hold, idex_hold, exmem_hold = 1; memwb_clear=1 (a bubble enters WB). No other clears.
2. FLUSH (ex_branch_taken=1): ifid_clear=1 and idex_clear=1; PC not held, so the branch target loads.
   - Branch wins over a load-use or MD stall because the stalled ID instruction is wrong-path.
3. LOAD_USE: condition is ex_mem_read & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
   - Action: pc_hold=1, ifid_hold=1, idex_clear=1. This gives exactly one bubble per occurrence.
4. MD_STALL (id_md_use & md_busy): same action as LOAD_USE; repeats every cycle until md_busy=0.
5. NONE: all controls 0.

Mult/div FSM (states IDLE, BUSY; down-counter md_cnt of width clog2(MD_LAT+1)):
- IDLE: if ex_md_start & ~mem_stall & ~reset, go to BUSY with md_cnt=MD_LAT.
- BUSY: md_cnt decrements every cycle, including during mem_stall. When md_cnt==1 at the edge, go to IDLE.
- md_busy = (state==BUSY). With MD_LAT=4 and start accepted at edge k, md_busy is high for cycles k+1 through k+4.
- ex_md_start while BUSY cannot occur (ID is stalled by id_md_use). If it does occur, it is ignored and flagged by a bench assertion.
- ex_md_start during mem_stall is not accepted. It is accepted on the first cycle with mem_stall=0 (the EX register was held).

stall_cycles:
- Increments at each edge where pc_hold=1 and reset=0.
- Saturates at all-ones.

hazard_cause encoding: 0 NONE, 1 MEM_STALL, 2 FLUSH, 3 LOAD_USE, 4 MD_STALL.

Decomposition:
- Package mips_pkg holds:
  - hazard_cause_t enum (3 bits, values above)
  - md_state_t enum {IDLE, BUSY}
  - constant REG_ZERO = 5'd0
- Sub-module md_tracker holds the FSM and counter.
  - Inputs: clk, reset, start_valid.
  - Output: md_busy.
- pipeline_ctrl holds the priority logic and stall counter.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 -> one cycle with pc_hold=ifid_hold=idex_clear=1, hazard_cause=3, stall_cycles 0->1. Repeat with ex_rd=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 while the load-use condition is also true -> ifid_clear=idex_clear=1, pc_hold=0, cause=2.
- mem_stall high for 3 cycles while a branch is taken -> MEM_STALL actions on all 3 cycles, cause=1, stall_cycles +=3. FLUSH on the cycle after mem_stall drops.
- MD_LAT=4: ex_md_start pulse, then id_md_use=1 held -> md_busy high 4 cycles. ID stalled 4 cycles (cause=4). Released on cycle 5; stall_cycles=4.
- ex_md_start with mem_stall=1 for 2 cycles -> start accepted only when mem_stall falls. md_busy rises the following cycle.
- Reset asserted while md_busy=1 with md_cnt=2 -> md_busy=0 immediately. All clears=1 and stall_cycles=0 during reset. Normal operation after release. Saturation: preload near max via a CNT_W=4 build, stall 20 cycles -> stall_cycles stays 15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/sequencing control.
package mips_pkg;

  // Reason for this cycle's pipeline-control action, highest priority first.
  typedef enum logic [2:0] {
    HC_NONE      = 3'd0,
    HC_MEM_STALL = 3'd1,
    HC_FLUSH     = 3'd2,
    HC_LOAD_USE  = 3'd3,
    HC_MD_STALL  = 3'd4
  } hazard_cause_t;

  // Occupancy state of the multi-cycle mult/div unit.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/md_tracker.sv
// Tracks mult/div unit occupancy: busy for exactly MD_LAT cycles after an
// accepted start. The count keeps running through memory stalls because the
// unit itself is not held by the pipeline registers.
module md_tracker
  import mips_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_valid,
  output logic md_busy
);

  localparam int CW = $clog2(MD_LAT + 1);

  md_state_t       state;
  logic [CW-1:0]   md_cnt;

  // Occupancy FSM with a down-counter; md_busy is registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state   <= BUSY;
            md_cnt  <= CW'(MD_LAT);
            md_busy <= 1'b1;
          end
        end
        BUSY: begin
          md_cnt <= md_cnt - CW'(1);
          if (md_cnt == CW'(1)) begin
            state   <= IDLE;
            md_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline. Resolves
// memory wait, branch flush, load-use and mult/div stalls in fixed priority
// and drives the pipeline-register hold/clear lines plus a stall counter.
module pipeline_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32,
  parameter int RA_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_use,
  input  logic             ex_mem_read,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             mem_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_clear,
  output logic             idex_hold,
  output logic             idex_clear,
  output logic             exmem_hold,
  output logic             exmem_clear,
  output logic             memwb_hold,
  output logic             memwb_clear,
  output logic             md_busy,
  output logic [2:0]       hazard_cause,
  output logic [CNT_W-1:0] stall_cycles
);

  hazard_cause_t cause;
  logic          load_use;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A start held in EX during a memory wait is taken once the wait ends.
  md_tracker #(.MD_LAT(MD_LAT)) u_md (
    .clk         (clk),
    .reset       (reset),
    .start_valid (ex_md_start & ~mem_stall),
    .md_busy     (md_busy)
  );

  assign load_use = ex_mem_read && (ex_rd != RA_W'(REG_ZERO)) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  // Priority resolution: exactly one case drives the controls each cycle.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_clear  = 1'b0;
    idex_hold   = 1'b0;
    idex_clear  = 1'b0;
    exmem_hold  = 1'b0;
    exmem_clear = 1'b0;
    memwb_hold  = 1'b0;
    memwb_clear = 1'b0;
    cause       = HC_NONE;
    if (reset) begin
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
      memwb_clear = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to MEM; WB gets a bubble.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_clear = 1'b1;
      cause       = HC_MEM_STALL;
    end else if (ex_branch_taken) begin
      // Wrong-path IF and ID instructions are dropped; PC takes the target.
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      cause       = HC_FLUSH;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_clear  = 1'b1;
      cause       = HC_LOAD_USE;
    end else if (id_md_use && md_busy) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_clear  = 1'b1;
      cause       = HC_MD_STALL;
    end
  end

  assign hazard_cause = cause;

  // Performance counter of cycles in which fetch was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (pc_hold) begin
      stall_cycles <= sat_inc(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized check of pipeline_ctrl against a behavioural model
// of the hazard priority rules, mult/div occupancy and the stall counter.
module tb_pipeline_ctrl;

  localparam int MD_LAT = 4;
  localparam int RA_W   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [RA_W-1:0] id_rs, id_rt, ex_rd;
  logic            id_use_rs, id_use_rt, id_md_use;
  logic            ex_mem_read, ex_branch_taken, ex_md_start, mem_stall;

  logic pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
  logic exmem_hold, exmem_clear, memwb_hold, memwb_clear, md_busy;
  logic [2:0]  hazard_cause;
  logic [31:0] stall_cycles;

  logic s_pc_hold, s_ifid_hold, s_ifid_clear, s_idex_hold, s_idex_clear;
  logic s_exmem_hold, s_exmem_clear, s_memwb_hold, s_memwb_clear, s_md_busy;
  logic [2:0] s_hazard_cause;
  logic [3:0] s_stall_cycles;

  logic [8:0] ctl, s_ctl;
  assign ctl   = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
                  exmem_hold, exmem_clear, memwb_hold, memwb_clear};
  assign s_ctl = {s_pc_hold, s_ifid_hold, s_ifid_clear, s_idex_hold, s_idex_clear,
                  s_exmem_hold, s_exmem_clear, s_memwb_hold, s_memwb_clear};

  pipeline_ctrl #(.MD_LAT(MD_LAT), .CNT_W(32), .RA_W(RA_W)) u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_use(id_md_use),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .mem_stall(mem_stall),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_clear(ifid_clear),
    .idex_hold(idex_hold), .idex_clear(idex_clear),
    .exmem_hold(exmem_hold), .exmem_clear(exmem_clear),
    .memwb_hold(memwb_hold), .memwb_clear(memwb_clear),
    .md_busy(md_busy), .hazard_cause(hazard_cause), .stall_cycles(stall_cycles)
  );

  // Narrow-counter build used to observe saturation.
  pipeline_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4), .RA_W(RA_W)) u_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_use(id_md_use),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .mem_stall(mem_stall),
    .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .ifid_clear(s_ifid_clear),
    .idex_hold(s_idex_hold), .idex_clear(s_idex_clear),
    .exmem_hold(s_exmem_hold), .exmem_clear(s_exmem_clear),
    .memwb_hold(s_memwb_hold), .memwb_clear(s_memwb_clear),
    .md_busy(s_md_busy), .hazard_cause(s_hazard_cause), .stall_cycles(s_stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: cycles of mult/div occupancy left, and held-fetch count.
  int busy_rem = 0;
  int cnt      = 0;

  logic [8:0] exp_ctl;
  logic [2:0] exp_cause;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control vector bit order: pc, ifid h/c, idex h/c, exmem h/c, memwb h/c.
  task automatic model_outputs();
    logic lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (reset)                         begin exp_ctl = 9'b001010101; exp_cause = 3'd0; end
    else if (mem_stall)                begin exp_ctl = 9'b110101001; exp_cause = 3'd1; end
    else if (ex_branch_taken)          begin exp_ctl = 9'b001010000; exp_cause = 3'd2; end
    else if (lu)                       begin exp_ctl = 9'b110010000; exp_cause = 3'd3; end
    else if (id_md_use && busy_rem > 0) begin exp_ctl = 9'b110010000; exp_cause = 3'd4; end
    else                               begin exp_ctl = 9'b000000000; exp_cause = 3'd0; end
  endtask

  task automatic check_now(input string tag);
    int sat_exp;
    if (reset) begin
      busy_rem = 0;
      cnt      = 0;
    end
    model_outputs();
    sat_exp = (cnt > 15) ? 15 : cnt;
    chk({tag, ".ctl"},   64'(ctl), 64'(exp_ctl));
    chk({tag, ".cause"}, 64'(hazard_cause), 64'(exp_cause));
    chk({tag, ".busy"},  64'(md_busy), 64'(busy_rem > 0));
    chk({tag, ".cnt"},   64'(stall_cycles), 64'(cnt));
    chk({tag, ".excl"},  64'(|(ctl[7:0] & {ctl[6:0], 1'b0} & 8'b10101010)), 64'd0);
    chk({tag, ".s_ctl"}, 64'(s_ctl), 64'(exp_ctl));
    chk({tag, ".s_cause"}, 64'(s_hazard_cause), 64'(exp_cause));
    chk({tag, ".s_busy"},  64'(s_md_busy), 64'(busy_rem > 0));
    chk({tag, ".s_cnt"},   64'(s_stall_cycles), 64'(sat_exp));
  endtask

  // Check mid-cycle, then advance the model across the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    if (reset) begin
      busy_rem = 0;
      cnt      = 0;
    end else begin
      if (exp_ctl[8]) cnt++;
      if (busy_rem > 0) busy_rem--;
      else if (ex_md_start && !mem_stall) busy_rem = MD_LAT;
    end
    #1;
  endtask

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_md_use = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    #1;
    step("reset0");
    step("reset1");
    reset = 1'b0;
    step("idle");

    // Load-use on rs, then no dependency once EX destination is $zero.
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    step("lu_rs");
    clear_in();
    step("lu_after");
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    step("lu_zero");
    ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; id_rs = 5'd3;
    step("lu_rt");
    id_use_rt = 1'b0;
    step("lu_unused");

    // Branch beats a simultaneous load-use.
    clear_in();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; ex_branch_taken = 1'b1;
    step("br_over_lu");

    // Memory wait beats a taken branch; flush follows once the wait ends.
    clear_in();
    ex_branch_taken = 1'b1; mem_stall = 1'b1;
    repeat (3) step("mstall_br");
    mem_stall = 1'b0;
    step("br_after_ms");
    clear_in();

    // Mult/div occupancy stalls a dependent ID instruction MD_LAT cycles.
    ex_md_start = 1'b1;
    step("md_start");
    ex_md_start = 1'b0; id_md_use = 1'b1;
    repeat (MD_LAT + 1) step("md_wait");
    clear_in();

    // Start presented during a memory wait is taken only after it ends.
    ex_md_start = 1'b1; mem_stall = 1'b1;
    repeat (2) step("md_ms");
    mem_stall = 1'b0;
    step("md_accept");
    ex_md_start = 1'b0;
    repeat (MD_LAT + 1) step("md_drain");

    // Asynchronous reset part-way through a busy count.
    ex_md_start = 1'b1;
    step("md_start2");
    ex_md_start = 1'b0;
    repeat (2) step("md_run2");
    reset = 1'b1;
    #1;
    check_now("rst_async");
    step("rst_hold");
    reset = 1'b0;
    step("rst_release");
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rt = 5'd4; id_use_rt = 1'b1;
    step("lu_post_rst");
    clear_in();

    // Long memory wait drives the narrow counter into saturation.
    mem_stall = 1'b1;
    repeat (20) step("sat");
    clear_in();
    step("sat_end");

    // Randomized traffic with small register ranges to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      id_md_use       = ($urandom_range(0, 2) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_stall       = ($urandom_range(0, 5) == 0);
      ex_md_start     = (busy_rem == 0) && ($urandom_range(0, 5) == 0);
      reset           = ($urandom_range(0, 49) == 0);
      step("rnd");
    end
    reset = 1'b0;
    clear_in();
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
